// File: rtl/ddr2_ui_pkg.sv
// Shared widths, FSM encoding and byte-merge helper for the DDR2 UI responder.
package ddr2_ui_pkg;

    localparam int unsigned ADDR_W = 31;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CMD_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR0,
        S_WR1,
        S_RDW,
        S_RD0,
        S_RD1
    } state_e;

    // A set mask bit keeps the old byte; a clear bit takes the new byte.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [MASK_W-1:0] mask);
        logic [DATA_W-1:0] res;
        for (int b = 0; b < int'(MASK_W); b++) begin
            res[b*8 +: 8] = mask[b] ? old_word[b*8 +: 8] : new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr2_resp_fifo.sv
// Synchronous FIFO with registered almost-full; pushes into a full FIFO are dropped.
module ddr2_resp_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 4,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             afull_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign afull_o = afull_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        // Free entries = DEPTH - count; flag when that drops to the margin.
        afull_d = (32'(count_d) + AFULL_MARGIN) >= DEPTH;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ddr2_ui_responder.sv
// Behavioural DDR2 user-interface responder: command/write FIFOs, init delay, backing store.
// Define DDR2_RESP_MASK_EN to honour app_wdf_mask_data byte masks on writes.
module ddr2_ui_responder
    import ddr2_ui_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 64,
    parameter int unsigned AF_DEPTH     = 16,
    parameter int unsigned WDF_DEPTH    = 32,
    parameter int unsigned AFULL_MARGIN = 4,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned RD_LAT       = 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              phy_init_done,
    input  logic              app_af_wren,
    input  logic [ADDR_W-1:0] app_af_addr,
    input  logic              app_af_read,
    output logic              app_af_afull,
    input  logic              app_wdf_wren,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask_data,
    output logic              app_wdf_afull,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data_fifo_out,
    output logic              overflow
);

    localparam int unsigned       WORD_AW   = MEM_AW + 1;
    localparam int unsigned       INIT_W    = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam int unsigned       LAT_W     = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);
    localparam int unsigned       AF_CW     = $clog2(AF_DEPTH + 1);
    localparam int unsigned       WDF_CW    = $clog2(WDF_DEPTH + 1);
`ifdef DDR2_RESP_MASK_EN
    localparam int unsigned       WDF_W     = DATA_W + MASK_W;
`else
    localparam int unsigned       WDF_W     = DATA_W;
`endif

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                init_done_q, init_done_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                overflow_q, overflow_d;

    logic [CMD_W-1:0]    af_rdata;
    logic                af_empty, af_full, af_pop;
    logic [AF_CW-1:0]    af_count;
    logic [WDF_W-1:0]    wdf_wdata, wdf_rdata;
    logic                wdf_empty, wdf_full, wdf_pop;
    logic [WDF_CW-1:0]   wdf_count;
    logic [DATA_W-1:0]   wdf_data;
    logic [MASK_W-1:0]   wdf_mask;
    logic                head_read;
    logic [MEM_AW-1:0]   head_idx;
    logic                st_we;
    logic [WORD_AW-1:0]  st_addr;
    logic [DATA_W-1:0]   store_q [2**WORD_AW];
    logic                unused_bits;

`ifdef DDR2_RESP_MASK_EN
    assign wdf_wdata   = {app_wdf_mask_data, app_wdf_data};
    assign wdf_mask    = wdf_rdata[WDF_W-1:DATA_W];
    assign unused_bits = ^{af_count, wdf_empty, af_rdata[ADDR_W-1:MEM_AW+2], af_rdata[1:0]};
`else
    assign wdf_wdata   = app_wdf_data;
    assign wdf_mask    = '0;
    assign unused_bits = ^{af_count, wdf_empty, af_rdata[ADDR_W-1:MEM_AW+2], af_rdata[1:0],
                           app_wdf_mask_data};
`endif
    assign wdf_data  = wdf_rdata[DATA_W-1:0];
    assign head_read = af_rdata[CMD_W-1];
    // Each command covers two store words, so byte address bits [1:0] are dropped.
    assign head_idx  = af_rdata[MEM_AW+1:2];

    ddr2_resp_fifo #(
        .WIDTH        (CMD_W),
        .DEPTH        (AF_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .CNT_W        (AF_CW)
    ) u_af_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (app_af_wren),
        .wdata_i ({app_af_read, app_af_addr}),
        .pop_i   (af_pop),
        .rdata_o (af_rdata),
        .empty_o (af_empty),
        .full_o  (af_full),
        .afull_o (app_af_afull),
        .count_o (af_count)
    );

    ddr2_resp_fifo #(
        .WIDTH        (WDF_W),
        .DEPTH        (WDF_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .CNT_W        (WDF_CW)
    ) u_wdf_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (app_wdf_wren),
        .wdata_i (wdf_wdata),
        .pop_i   (wdf_pop),
        .rdata_o (wdf_rdata),
        .empty_o (wdf_empty),
        .full_o  (wdf_full),
        .afull_o (app_wdf_afull),
        .count_o (wdf_count)
    );

    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (!init_done_q) begin
            if (init_cnt_q == INIT_LAST) begin
                init_done_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
            end
        end
        overflow_d = overflow_q | (app_af_wren & af_full) | (app_wdf_wren & wdf_full);
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        af_pop  = 1'b0;
        wdf_pop = 1'b0;
        st_we   = 1'b0;
        st_addr = {idx_q, 1'b1};
        unique case (state_q)
            S_INIT: begin
                if (init_done_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!af_empty) begin
                    if (head_read) begin
                        af_pop  = 1'b1;
                        idx_d   = head_idx;
                        lat_d   = LAT_LOAD;
                        state_d = S_RDW;
                    end else if (wdf_count >= WDF_CW'(2)) begin
                        // Both beats must be present so the burst never stalls mid-way.
                        af_pop  = 1'b1;
                        wdf_pop = 1'b1;
                        idx_d   = head_idx;
                        st_we   = 1'b1;
                        st_addr = {head_idx, 1'b0};
                        state_d = S_WR0;
                    end
                end
            end
            S_WR0: begin
                wdf_pop = 1'b1;
                st_we   = 1'b1;
                state_d = S_WR1;
            end
            S_WR1: state_d = S_IDLE;
            S_RDW: begin
                if (lat_q == '0) begin
                    state_d = S_RD0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Read outputs are registered against the next state so valid lines up with S_RD0/S_RD1.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (state_d == S_RD0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = store_q[{idx_q, 1'b0}];
        end else if (state_d == S_RD1) begin
            rd_valid_d = 1'b1;
            rd_data_d  = store_q[{idx_q, 1'b1}];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            lat_q       <= '0;
            idx_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            lat_q       <= lat_d;
            idx_q       <= idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (st_we) begin
            store_q[st_addr] <= merge_bytes(store_q[st_addr], wdf_data, wdf_mask);
        end
    end

    assign phy_init_done    = init_done_q;
    assign rd_data_valid    = rd_valid_q;
    assign rd_data_fifo_out = rd_data_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_ddr2_ui_responder.sv
// Self-checking bench for ddr2_ui_responder: directed steps plus random traffic vs a store model.
module tb_ddr2_ui_responder;
    import ddr2_ui_pkg::*;

    localparam int unsigned INIT_CYCLES  = 64;
    localparam int unsigned AF_DEPTH     = 16;
    localparam int unsigned WDF_DEPTH    = 32;
    localparam int unsigned AFULL_MARGIN = 4;
    localparam int unsigned MEM_AW       = 10;
    localparam int unsigned RD_LAT       = 8;
    localparam int unsigned WORDS        = 2 ** (MEM_AW + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         phy_init_done, app_af_afull, app_wdf_afull, rd_data_valid, overflow;
    logic         app_af_wren = 1'b0, app_af_read = 1'b0, app_wdf_wren = 1'b0;
    logic [30:0]  app_af_addr = '0;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask_data = '0;
    logic [127:0] rd_data_fifo_out;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int push_cyc = 0;
    logic [127:0] model_mem [WORDS];
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int           got_cyc_q[$];
    logic [30:0]  wr_addrs[$];

    ddr2_ui_responder #(
        .INIT_CYCLES  (INIT_CYCLES),
        .AF_DEPTH     (AF_DEPTH),
        .WDF_DEPTH    (WDF_DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .MEM_AW       (MEM_AW),
        .RD_LAT       (RD_LAT)
    ) dut (
        .CLK               (clk),
        .RST               (rst_n),
        .phy_init_done     (phy_init_done),
        .app_af_wren       (app_af_wren),
        .app_af_addr       (app_af_addr),
        .app_af_read       (app_af_read),
        .app_af_afull      (app_af_afull),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask_data (app_wdf_mask_data),
        .app_wdf_afull     (app_wdf_afull),
        .rd_data_valid     (rd_data_valid),
        .rd_data_fifo_out  (rd_data_fifo_out),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rd_data_valid) begin
            got_q.push_back(rd_data_fifo_out);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {127'b0, obs}, {127'b0, exp});
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        check(tag, {96'b0, obs}, {96'b0, exp});
    endtask

    function automatic int widx(input logic [30:0] a, input int beat);
        return ((int'(a) / 4) % (1 << MEM_AW)) * 2 + beat;
    endfunction

    function automatic logic [127:0] apply(input logic [127:0] old_w, input logic [127:0] new_w,
                                           input logic [15:0] m);
        logic [127:0] r;
        logic [15:0]  keep;
        r = old_w;
`ifdef DDR2_RESP_MASK_EN
        keep = m;
`else
        keep = m & 16'h0000;
`endif
        for (int j = 0; j < 16; j++) begin
            if (!keep[j]) r[j*8 +: 8] = new_w[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic af_push(input logic rd, input logic [30:0] a);
        @(negedge clk);
        app_af_wren = 1'b1;
        app_af_read = rd;
        app_af_addr = a;
        push_cyc    = cyc + 1;
        @(negedge clk);
        app_af_wren = 1'b0;
    endtask

    task automatic wdf_push(input logic [127:0] d, input logic [15:0] m);
        @(negedge clk);
        app_wdf_wren      = 1'b1;
        app_wdf_data      = d;
        app_wdf_mask_data = m;
        @(negedge clk);
        app_wdf_wren = 1'b0;
    endtask

    task automatic do_write(input logic [30:0] a, input logic [127:0] d0, input logic [15:0] m0,
                            input logic [127:0] d1, input logic [15:0] m1);
        model_mem[widx(a, 0)] = apply(model_mem[widx(a, 0)], d0, m0);
        model_mem[widx(a, 1)] = apply(model_mem[widx(a, 1)], d1, m1);
        af_push(1'b0, a);
        wdf_push(d0, m0);
        wdf_push(d1, m1);
    endtask

    task automatic do_read(input logic [30:0] a);
        exp_q.push_back(model_mem[widx(a, 0)]);
        exp_q.push_back(model_mem[widx(a, 1)]);
        af_push(1'b1, a);
    endtask

    task automatic wait_beats(input int n);
        for (int t = 0; t < 3000 && got_q.size() < n; t++) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        wait_beats(exp_q.size());
        repeat (4) @(negedge clk);
        check_int({tag, "_beats"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check(tag, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    initial begin
        int          first;
        logic [127:0] d0, d1, exp_b0;
        logic [30:0]  a;

        repeat (3) @(negedge clk);
        check1("rst_init_done", phy_init_done, 1'b0);
        check1("rst_af_afull", app_af_afull, 1'b0);
        check1("rst_wdf_afull", app_wdf_afull, 1'b0);
        check1("rst_valid", rd_data_valid, 1'b0);
        check("rst_rdata", rd_data_fifo_out, '0);
        check1("rst_overflow", overflow, 1'b0);

        // Init delay: count rising edges after release.
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= int'(INIT_CYCLES) + 20; k++) begin
            @(posedge clk);
            #1;
            if (phy_init_done && first < 0) first = k;
        end
        check_int("init_edge", first, INIT_CYCLES);
        check1("init_held", phy_init_done, 1'b1);

        // Basic write then read at address 0, with exact latency.
        do_write(31'h0, 128'h1, 16'h0, 128'h2, 16'h0);
        repeat (5) @(negedge clk);
        do_read(31'h0);
        wait_beats(2);
        check("wr_rd_beat0", got_q[0], 128'h1);
        check("wr_rd_beat1", got_q[1], 128'h2);
        check_int("rd_latency", got_cyc_q[0] - push_cyc, RD_LAT + 1);
        check_int("rd_beats_adjacent", got_cyc_q[1] - got_cyc_q[0], 1);
        drain("wr_rd");

        // Byte mask on a partial overwrite.
        do_write(31'h4, {128{1'b1}}, 16'h0, rnd128(), 16'h0);
        do_write(31'h4, '0, 16'h00FF, '0, 16'h00FF);
        do_read(31'h4);
        wait_beats(1);
`ifdef DDR2_RESP_MASK_EN
        exp_b0 = {64'h0, {64{1'b1}}};
`else
        exp_b0 = '0;
`endif
        check("mask_beat0", got_q[0], exp_b0);
        drain("mask");

        // Upper address bits ignored: 0x1000 aliases 0x0.
        d0 = rnd128();
        d1 = rnd128();
        do_write(31'h1000, d0, 16'h0, d1, 16'h0);
        do_read(31'h0);
        wait_beats(2);
        check("wrap_beat0", got_q[0], d0);
        check("wrap_beat1", got_q[1], d1);
        drain("wrap");

        // Random traffic in small batches so the command FIFO never fills.
        for (int batch = 0; batch < 5; batch++) begin
            for (int op = 0; op < 6; op++) begin
                if (wr_addrs.size() == 0 || $urandom_range(1, 0) == 0) begin
                    a = 31'($urandom);
                    a[11:2] = 10'($urandom_range(31, 0));
                    wr_addrs.push_back(a);
                    do_write(a, rnd128(), 16'($urandom), rnd128(), 16'($urandom));
                end else begin
                    a = 31'($urandom);
                    a[11:2] = wr_addrs[$urandom_range(wr_addrs.size() - 1, 0)][11:2];
                    do_read(a);
                end
            end
            drain("rand");
        end

        // Stall writes with an empty WDF so the command FIFO fills up.
        for (int i = 0; i < 17; i++) begin
            af_push(1'b0, 31'(i * 4));
            if (i == 10) check1("af_afull_11", app_af_afull, 1'b0);
            if (i == 11) check1("af_afull_12", app_af_afull, 1'b1);
            if (i == 15) check1("ovf_before_17", overflow, 1'b0);
            if (i == 16) check1("ovf_after_17", overflow, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            d0 = rnd128();
            d1 = rnd128();
            model_mem[widx(31'(i * 4), 0)] = d0;
            model_mem[widx(31'(i * 4), 1)] = d1;
            wdf_push(d0, 16'h0);
            wdf_push(d1, 16'h0);
        end
        do_read(31'h0);
        do_read(31'd20);
        do_read(31'd60);
        drain("stall_rb");
        check1("af_afull_clear", app_af_afull, 1'b0);

        // Reset asserted while the first read beat is on the bus.
        do_read(31'h0);
        for (int t = 0; t < 200 && !rd_data_valid; t++) @(negedge clk);
        check1("rd0_reached", rd_data_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rst_rd0_valid", rd_data_valid, 1'b0);
        check1("rst_rd0_af_afull", app_af_afull, 1'b0);
        check1("rst_rd0_done", phy_init_done, 1'b0);
        check1("rst_rd0_ovf", overflow, 1'b0);
        check("rst_rd0_state", 128'(dut.state_q), 128'(S_INIT));
        @(negedge clk);
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        rst_n = 1'b1;

        // WDF fill during init: nothing pops it without commands.
        for (int i = 1; i <= 33; i++) begin
            wdf_push(rnd128(), 16'h0);
            if (i == 1) check1("pre_init_done", phy_init_done, 1'b0);
            if (i == 27) check1("wdf_afull_27", app_wdf_afull, 1'b0);
            if (i == 28) check1("wdf_afull_28", app_wdf_afull, 1'b1);
            if (i == 32) check1("wdf_ovf_32", overflow, 1'b0);
            if (i == 33) check1("wdf_ovf_33", overflow, 1'b1);
        end
        check_int("no_stray_beats", got_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
